// File: rtl/div_share_ctrl.sv
// Round-robin front end for one shared non-restoring unsigned divider.
// One division is in flight at a time. The result is tagged with the id of the requester that was granted.
module div_share_ctrl #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       dividend,
    input  logic [NREQ*W-1:0]       divisor,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [W-1:0]            quotient,
    output logic [W-1:0]            remainder,
    output logic                    div_zero
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic            done_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  done_id_q;
    logic [W-1:0]    mq_q;
    logic [W-1:0]    b_q;
    logic [W:0]      a_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    quot_q;
    logic [W-1:0]    rem_q;
    logic            dz_q;

    logic            win_found_c;
    logic [IDW-1:0]  win_idx_c;
    logic [W-1:0]    op_a_c;
    logic [W-1:0]    op_b_c;
    logic [W:0]      shifted_c;
    logic [W:0]      a_step_c;
    logic [W:0]      a_fix_c;

    // Search for the first request, starting one slot after the last winner.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!win_found_c && req[IDW'((32'(ptr_q) + k) % NREQ)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDW'((32'(ptr_q) + k) % NREQ);
            end
        end
        op_a_c = dividend[32'(win_idx_c) * W +: W];
        op_b_c = divisor[32'(win_idx_c) * W +: W];
    end

    // The sign of partial remainder A chooses between subtract and add. FIX restores a negative A.
    always_comb begin
        shifted_c = {a_q[W-1:0], mq_q[W-1]};
        a_step_c  = a_q[W] ? (shifted_c + {1'b0, b_q}) : (shifted_c - {1'b0, b_q});
        a_fix_c   = a_q[W] ? (a_q + {1'b0, b_q}) : a_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ptr_q     <= IDW'(NREQ - 1);
            id_q      <= '0;
            done_id_q <= '0;
            mq_q      <= '0;
            b_q       <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (win_found_c) begin
                        gnt_q   <= NREQ'(1) << win_idx_c;
                        busy_q  <= 1'b1;
                        ptr_q   <= win_idx_c;
                        id_q    <= win_idx_c;
                        mq_q    <= op_a_c;
                        b_q     <= op_b_c;
                        a_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= (op_b_c == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    a_q   <= a_step_c;
                    mq_q  <= {mq_q[W-2:0], ~a_step_c[W]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    state_q   <= IDLE;
                    if (b_q == '0) begin
                        quot_q <= '1;
                        rem_q  <= mq_q;
                        dz_q   <= 1'b1;
                    end else begin
                        a_q    <= a_fix_c;
                        quot_q <= mq_q;
                        rem_q  <= a_fix_c[W-1:0];
                        dz_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: arbitration order, latency, arithmetic, divide by zero, operand isolation, mid-op reset.
module tb_div_share_ctrl;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] dividend;
    logic [NREQ*W-1:0] divisor;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [1:0]        done_id;
    logic [W-1:0]      quotient;
    logic [W-1:0]      remainder;
    logic              div_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n;
    int seen;
    int extra_gnt;

    div_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .dividend  (dividend),
        .divisor   (divisor),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_op(input int slot, input int a, input int b);
        dividend[slot*W +: W] = W'(a);
        divisor[slot*W +: W]  = W'(b);
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (gnt == '0 && cnt < 40);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (gnt != '0) extra_gnt++;
        end while (!done && cnt < 40);
    endtask

    task automatic chk_result(input string tag, input int q, input int r, input int id, input int dz);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_q"}, 32'(quotient), 32'(q));
        chk({tag, "_r"}, 32'(remainder), 32'(r));
        chk({tag, "_id"}, 32'(done_id), 32'(id));
        chk({tag, "_dz"}, 32'(div_zero), 32'(dz));
    endtask

    int order [6] = '{0, 1, 2, 3, 0, 1};
    int qexp  [4] = '{16, 15, 14, 13};
    int rexp  [4] = '{2, 0, 0, 2};

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        dividend  = '0;
        divisor   = '0;
        extra_gnt = 0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_id", 32'(done_id), 0);
        chk("rst_dz", 32'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 117 / 10 on slot 0
        set_op(0, 117, 10);
        req = 4'b0001;
        wait_gnt(n);
        chk("t1_gnt_lat", 32'(n), 1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        wait_done(n);
        chk("t1_lat", 32'(n), 9);
        chk("t1_busy_done", 32'(busy), 1);
        chk_result("t1", 11, 7, 0, 0);
        tick();
        chk("t1_done_off", 32'(done), 0);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_q_hold", 32'(quotient), 11);

        // 255 / 1 then 3 / 200 on slot 2
        set_op(2, 255, 1);
        req = 4'b0100;
        wait_gnt(n);
        chk("t2a_gnt", 32'(gnt), 32'h4);
        req = '0;
        wait_done(n);
        chk("t2a_lat", 32'(n), 9);
        chk_result("t2a", 255, 0, 2, 0);
        tick();
        chk("t2_busy_gap", 32'(busy), 0);
        set_op(2, 3, 200);
        req = 4'b0100;
        wait_gnt(n);
        chk("t2b_gnt", 32'(gnt), 32'h4);
        req = '0;
        wait_done(n);
        chk_result("t2b", 0, 3, 2, 0);

        // divide by zero on slot 1
        set_op(1, 5, 0);
        req = 4'b0010;
        wait_gnt(n);
        chk("t3_gnt", 32'(gnt), 32'h2);
        req = '0;
        wait_done(n);
        chk("t3_lat", 32'(n), 1);
        chk_result("t3", 255, 5, 1, 1);
        tick();
        chk("t3_done_off", 32'(done), 0);
        chk("t3_dz_hold", 32'(div_zero), 1);

        // all four request; fresh pointer gives order 0,1,2,3,0,1
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 50 + i * 10, i + 3);
        req = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            wait_gnt(n);
            chk($sformatf("t4_gnt_lat%0d", j), 32'(n), 1);
            chk($sformatf("t4_gnt%0d", j), 32'(gnt), 32'(1) << order[j]);
            req[order[j]] = 1'b0;
            wait_done(n);
            chk_result($sformatf("t4_%0d", j), qexp[order[j]], rexp[order[j]], order[j], 0);
            req[order[j]] = 1'b1;
        end
        req = '0;
        tick();
        tick();

        // operand change while iterating has no effect
        set_op(0, 117, 10);
        req = 4'b0001;
        wait_gnt(n);
        chk("t5_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();
        set_op(0, 200, 7);
        wait_done(n);
        chk("t5_lat", 32'(n), 7);
        chk_result("t5", 11, 7, 0, 0);
        chk("no_gnt_while_busy", 32'(extra_gnt), 0);

        // reset at iteration 4 aborts the op
        set_op(3, 117, 10);
        req = 4'b1000;
        wait_gnt(n);
        chk("t6_gnt", 32'(gnt), 32'h8);
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_q", 32'(quotient), 0);
        chk("t6_r", 32'(remainder), 0);
        chk("t6_id", 32'(done_id), 0);
        chk("t6_dz", 32'(div_zero), 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen++;
        end
        chk("t6_no_done", 32'(seen), 0);
        set_op(1, 100, 9);
        req = 4'b0010;
        wait_gnt(n);
        chk("t6_gnt_lat", 32'(n), 1);
        chk("t6_gnt_after", 32'(gnt), 32'h2);
        req = '0;
        wait_done(n);
        chk("t6_lat", 32'(n), 9);
        chk_result("t6", 11, 1, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin scheduler that shares one 8-step non-restoring unsigned divider datapath among NREQ requesters.
- Arbitrates requests, latches the winner's operands and sequences the shift/add-subtract iterations and the final remainder correction.
- Returns quotient/remainder tagged with the requester id.
- Sits between client blocks and the division datapath; only one division is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/result width in bits; the iteration count equals W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level; held until that requester's gnt bit is seen.
- dividend  input  NREQ*W  packed dividends; slot i occupies bits [i*W +: W].
- divisor  input  NREQ*W  packed divisors, same packing as dividend.
- gnt  output  NREQ  one-hot, one-cycle pulse; operands of that slot latched on the same edge.
- busy  output  1  high from grant edge until the done edge inclusive.
- done  output  1  one-cycle pulse; result outputs valid while high.
- done_id  output  clog2(NREQ)  index of the requester whose result is presented.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder, 0 <= remainder < divisor.
- div_zero  output  1  result came from a zero divisor; valid with done.

Behaviour:
- Reset (async assert, sync release): state IDLE, gnt=0, busy=0, done=0, done_id=0, quotient=0, remainder=0, div_zero=0, count=0, rr pointer=NREQ-1 (req[0] has first priority).
- FSM states are IDLE, ITER, FIX.
- IDLE, any req high at edge E0:
  - Winner is the first set bit searching from pointer+1 upward, wrapping modulo NREQ.
  - gnt[winner]=1 for exactly one cycle; busy=1; pointer=winner.
  - Latch dividend into MQ, divisor into B, clear A (W+1 bits, sign in MSB), count=0.
  - Next state is ITER, or FIX when the latched divisor is 0.
- ITER, edges E1..EW, one step per edge:
  - If A>=0: A = (A<<1 | MQ msb) - B. Otherwise: A = (A<<1 | MQ msb) + B.
  - MQ = MQ<<1 with new lsb = ~A_new sign; count++.
  - After W steps go to FIX.
- FIX, edge EW+1:
  - If A<0 then A += B.
  - quotient=MQ, remainder=A[W-1:0], done_id=winner, div_zero=0, done=1.
  - busy stays 1 this cycle; next state IDLE.
- Zero divisor: FIX at E1 outputs quotient=all ones, remainder=latched dividend, div_zero=1, done=1. No iterations are run.
- Latency:
  - Normal: gnt in the cycle after E0, done in the cycle after E(W+1) (W+1 cycles after grant).
  - Next arbitration no earlier than edge E(W+2).
- done, busy and gnt deassert on the edge after their pulse cycle.
- quotient, remainder, done_id and div_zero hold their values until the next done.
- Input changes after the grant edge have no effect on the in-flight operation. A req that stays high after its gnt is treated as a new request.
- Simultaneous requests: exactly one gnt bit per arbitration; gnt is never asserted while busy.
- A requester whose req drops before being granted is skipped.
- Reset mid-operation aborts immediately: no done pulse, outputs return to reset values, pointer returns to NREQ-1.
- Arithmetic is unsigned on W-bit operands. A is W+1 bits so the add/subtract never overflows.

Test Plan:
- Reset, then req[0] with 117/10 -> gnt[0] one cycle, done 9 cycles later, quotient=11, remainder=7, done_id=0, div_zero=0.
- req[2] with 255/1, then 3/200 -> first result 255 r 0, second result 0 r 3; busy low between the two operations for at least one cycle.
- req[1] with 5/0 -> done in the cycle after the grant cycle, quotient=255, remainder=5, div_zero=1.
- req[3:0] all held high and each dropped on its own gnt, then re-raised -> grant order 0,1,2,3,0,1; never two gnt bits set; each done_id matches its grant.
- Change slot 0 operands to 200/7 during ITER of a 117/10 op -> result still 11 r 7.
- Assert rst_n=0 at iteration 4 -> all outputs 0 immediately, no done. After release, req[1] with 100/9 -> 11 r 1, granted first.
